// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input path.
// Holds the key codes of the operator/control keys (also used by the input
// controller), the keypad scanner state type, and a small column helper.
// No ports: package only.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'ha;
  localparam logic [3:0] KEY_SUB = 4'hb;
  localparam logic [3:0] KEY_MUL = 4'hc;
  localparam logic [3:0] KEY_DIV = 4'hd;
  localparam logic [3:0] KEY_EQ  = 4'he;
  localparam logic [3:0] KEY_CLR = 4'hf;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_e;

  // True when exactly one active-low column is asserted.
  function automatic logic one_low(input logic [3:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) ||
           (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad columns.
// Ports:
//   clk    - sampling clock
//   rst    - synchronous active-high reset, flops go to all-high (no key)
//   col_in - raw column inputs
//   col_s  - synchronized columns
module col_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] col_s
);

  logic [3:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 4'b1111;
      col_s  <= 4'b1111;
    end else begin
      meta_q <= col_in;
      col_s  <= meta_q;
    end
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner with debounce and key-code mapping.
// Rows are driven low one at a time; a single low column seen on the last
// dwell cycle of a row becomes a candidate, which must stay stable for
// DEBOUNCE_CYC cycles before it is accepted. Release is debounced the same way.
// Ports:
//   CLK_1K    - 1 kHz system clock
//   RST       - synchronous active-high reset
//   col_in    - keypad columns, active-low, asynchronous
//   row_out   - keypad rows, active-low, one row driven at a time
//   key_value - code of the last accepted key
//   flag      - one-cycle pulse when key_value is updated
//   key_down  - high from accepted press until accepted release
module key_scan
  import calc_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 3,
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_value,
  output logic       flag,
  output logic       key_down
);

  localparam int unsigned DwW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DwW-1:0] DwellLast = DwW'(ROW_DWELL - 1);
  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYC - 1);

  logic [3:0] col_s;

  col_sync u_col_sync (
    .clk    (CLK_1K),
    .rst    (RST),
    .col_in (col_in),
    .col_s  (col_s)
  );

  scan_state_e    state_q, state_d;
  logic [1:0]     row_q, row_d;
  logic [DwW-1:0] dwell_q, dwell_d;
  logic [DbW-1:0] cnt_q, cnt_d;
  logic [3:0]     cand_q, cand_d;
  logic [3:0]     key_value_q, key_value_d;
  logic           flag_q, flag_d;
  logic           key_down_q, key_down_d;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [3:0] cols);
    logic [1:0] col;
    logic [3:0] code;
    col = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!cols[i]) col = 2'(i);
    end
    unique case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = KEY_ADD;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = KEY_SUB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = KEY_MUL;
      4'd12:   code = KEY_CLR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_EQ;
      default: code = KEY_DIV;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_value_d = key_value_q;
    flag_d      = 1'b0;
    key_down_d  = key_down_q;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (one_low(col_s)) begin
            // Keep the row driven so the candidate stays visible.
            cand_d  = col_s;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s == cand_q) begin
          if (cnt_q == DbLast) begin
            key_value_d = key_map(row_q, cand_q);
            flag_d      = 1'b1;
            key_down_d  = 1'b1;
            cnt_d       = '0;
            state_d     = HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          dwell_d = '0;
          state_d = SCAN;
        end
      end
      HELD: begin
        if (col_s == 4'b1111) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (col_s != 4'b1111) begin
          // Release bounce: fall back and wait for a quiet line again.
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == DbLast) begin
          key_down_d = 1'b0;
          cnt_d      = '0;
          dwell_d    = '0;
          row_d      = 2'd0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        dwell_d = '0;
        row_d   = 2'd0;
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge CLK_1K) begin
    if (RST) begin
      state_q     <= SCAN;
      row_q       <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cand_q      <= 4'b1111;
      key_value_q <= 4'h0;
      flag_q      <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_value_q <= key_value_d;
      flag_q      <= flag_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key_value = key_value_q;
  assign flag      = flag_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan: a keypad model turns a 16-bit pressed-key
// vector into column levels; expected key codes go into a scoreboard queue when
// a press is driven and are popped on every flag pulse.
module tb_key_scan;
  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_value;
  logic       flag;
  logic       key_down;

  logic [15:0] keys;
  logic [3:0]  sb[$];
  logic [3:0]  exp_code[16];
  int          total;
  int          passed;
  int          flag_cnt;
  logic        prev_flag;

  key_scan #(
    .ROW_DWELL    (3),
    .DEBOUNCE_CYC (20)
  ) dut (
    .CLK_1K    (clk),
    .RST       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_value (key_value),
    .flag      (flag),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shorts its row to its column.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_keydown(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (key_down !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, key_down}, {31'b0, val});
  endtask

  // Flag monitor / scoreboard consumer.
  initial prev_flag = 1'b0;
  always @(negedge clk) begin
    if (flag === 1'b1) begin
      flag_cnt++;
      check("flag_single_cycle", {31'b0, prev_flag}, 32'd0);
      check("flag_expected", {31'b0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) check("flag_code", {28'b0, key_value}, {28'b0, sb.pop_front()});
    end
    prev_flag = flag;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    total    = 0;
    passed   = 0;
    flag_cnt = 0;
    keys     = 16'h0;
    rst      = 1'b1;
    exp_code = '{4'h1, 4'h2, 4'h3, 4'ha, 4'h4, 4'h5, 4'h6, 4'hb,
                 4'h7, 4'h8, 4'h9, 4'hc, 4'hf, 4'h0, 4'he, 4'hd};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_row_out", {28'b0, row_out}, 32'he);
    check("rst_key_value", {28'b0, key_value}, 32'h0);
    check("rst_flag", {31'b0, flag}, 32'd0);
    check("rst_key_down", {31'b0, key_down}, 32'd0);
    rst = 1'b0;

    // Clean press of r1c1
    sb.push_back(4'h5);
    keys[5] = 1'b1;
    repeat (60) @(negedge clk);
    check("t1_key_down", {31'b0, key_down}, 32'd1);
    check("t1_key_value", {28'b0, key_value}, 32'h5);
    keys[5] = 1'b0;
    wait_keydown(1'b0, 100, "t1_release");
    check("t1_row0_resume", {28'b0, row_out}, 32'he);
    check("t1_flag_cnt", flag_cnt, 32'd1);

    // Short bounces on r2c3 are rejected
    keys[11] = 1'b1;
    repeat (7) @(negedge clk);
    keys[11] = 1'b0;
    repeat (5) @(negedge clk);
    keys[11] = 1'b1;
    repeat (10) @(negedge clk);
    keys[11] = 1'b0;
    repeat (40) @(negedge clk);
    check("t2_flag_cnt", flag_cnt, 32'd1);
    check("t2_key_value", {28'b0, key_value}, 32'h5);
    check("t2_key_down", {31'b0, key_down}, 32'd0);

    // Long hold of r3c2 with short release bounces
    sb.push_back(4'he);
    keys[14] = 1'b1;
    repeat (100) @(negedge clk);
    check("t3_key_down", {31'b0, key_down}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      keys[14] = 1'b0;
      repeat (3) @(negedge clk);
      keys[14] = 1'b1;
      repeat (80) @(negedge clk);
      check("t3_still_down", {31'b0, key_down}, 32'd1);
    end
    check("t3_flag_cnt_held", flag_cnt, 32'd2);
    keys[14] = 1'b0;
    wait_keydown(1'b0, 100, "t3_release");
    check("t3_key_value", {28'b0, key_value}, 32'he);

    // Two keys in one row: invalid until one is released
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    repeat (60) @(negedge clk);
    check("t4_no_flag", flag_cnt, 32'd2);
    check("t4_key_down", {31'b0, key_down}, 32'd0);
    sb.push_back(4'h1);
    keys[1] = 1'b0;
    wait_keydown(1'b1, 100, "t4_press");
    check("t4_key_value", {28'b0, key_value}, 32'h1);
    keys[0] = 1'b0;
    wait_keydown(1'b0, 100, "t4_release");

    // Reset at debounce count 10 on r3c0
    for (int n = 0; n < 50 && row_out !== 4'b0111; n++) @(negedge clk);
    check("t5_row3", {28'b0, row_out}, 32'h7);
    keys[12] = 1'b1;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_row_out", {28'b0, row_out}, 32'he);
    check("t5_rst_key_value", {28'b0, key_value}, 32'h0);
    check("t5_rst_key_down", {31'b0, key_down}, 32'd0);
    check("t5_no_flag", flag_cnt, 32'd3);
    sb.push_back(4'hf);
    wait_keydown(1'b1, 200, "t5_redetect");
    check("t5_key_value", {28'b0, key_value}, 32'hf);
    keys[12] = 1'b0;
    wait_keydown(1'b0, 100, "t5_release");

    // Sweep all keys
    for (int i = 0; i < 16; i++) begin
      sb.push_back(exp_code[i]);
      keys[i] = 1'b1;
      wait_keydown(1'b1, 200, "sweep_press");
      keys[i] = 1'b0;
      wait_keydown(1'b0, 200, "sweep_release");
    end
    repeat (5) @(negedge clk);
    check("final_flag_cnt", flag_cnt, 32'd20);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
